// File: rtl/disp_vram_rdslave.sv
// disp_vram_rdslave: AXI4 read responder serving display VRAM bursts.
// Two-deep AR queue, INCR burst engine, two-slot R skid with bypass.
module disp_vram_rdslave #(
  parameter int MEM_AW    = 16,
  parameter int MEM_WORDS = 65536
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [31:0]       ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              MEM_EN,
  output logic [MEM_AW-1:0] MEM_ADDR,
  input  logic [31:0]       MEM_RDATA
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  localparam logic [31:0] WLIM = 32'(MEM_WORDS);

  logic [1:0]  fcnt_q, fcnt_d;
  logic [29:0] fa0_q, fa0_d, fa1_q, fa1_d;
  logic [7:0]  fl0_q, fl0_d, fl1_q, fl1_d;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  rem_q, rem_d;

  logic        pv_q, pv_d;
  logic        pl_q, pl_d;
  logic        po_q, po_d;

  logic [1:0]  scnt_q, scnt_d;
  logic [31:0] sk0_data_q, sk0_data_d;
  logic [31:0] sk1_data_q, sk1_data_d;
  logic [1:0]  sk0_resp_q, sk0_resp_d;
  logic [1:0]  sk1_resp_q, sk1_resp_d;
  logic        sk0_last_q, sk0_last_d;
  logic        sk1_last_q, sk1_last_d;

  logic        arready, push, fpop;
  logic        issue, oor, last_beat, room;
  logic        rvalid, rpop, sk_pop, cap;
  logic [1:0]  occ, fq_n, sk_n;
  logic [31:0] cur_addr;
  logic [7:0]  cur_rem;
  logic [31:0] pe_data, hd_data;
  logic [1:0]  pe_resp, hd_resp;
  logic        hd_last;
  logic        unused_lsb;

  assign unused_lsb = ^ARADDR[1:0];

  // Handshake gating and the beat-issue decision for this cycle
  always_comb begin
    arready  = !ARST && (fcnt_q != 2'd2);
    push     = ARVALID && arready;
    rvalid   = (scnt_q != 2'd0) || pv_q;
    rpop     = rvalid && RREADY;
    occ      = scnt_q + {1'b0, pv_q};
    room     = (occ - {1'b0, rpop}) < 2'd2;
    cur_addr = {2'b00, fa0_q};
    cur_rem  = fl0_q;
    if (state_q == S_BURST) begin
      cur_addr = addr_q;
      cur_rem  = rem_q;
    end
    issue     = !ARST && room &&
                ((state_q == S_BURST) || (fcnt_q != 2'd0));
    oor       = cur_addr >= WLIM;
    last_beat = cur_rem == 8'd0;
  end

  assign ARREADY  = arready;
  assign MEM_EN   = issue && !oor;
  assign MEM_ADDR = MEM_EN ? cur_addr[MEM_AW-1:0] : '0;

  // Burst engine: idle issues straight from the queue head
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    fpop    = 1'b0;
    if (issue) begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          fpop = 1'b1;
          if (!last_beat) begin
            state_d = S_BURST;
            addr_d  = cur_addr + 32'd1;
            rem_d   = fl0_q - 8'd1;
          end
        end
        (state_q == S_BURST) && !last_beat: begin
          addr_d = addr_q + 32'd1;
          rem_d  = rem_q - 8'd1;
        end
        (state_q == S_BURST) && last_beat && (fcnt_q != 2'd0): begin
          fpop   = 1'b1;
          addr_d = {2'b00, fa0_q};
          rem_d  = fl0_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // AR queue: pop shifts the tail forward, push lands behind it
  always_comb begin
    fa0_d = fa0_q;
    fa1_d = fa1_q;
    fl0_d = fl0_q;
    fl1_d = fl1_q;
    fq_n  = fcnt_q;
    if (fpop) begin
      fa0_d = fa1_q;
      fl0_d = fl1_q;
      fq_n  = fq_n - 2'd1;
    end
    if (push) begin
      if (fq_n == 2'd0) begin
        fa0_d = ARADDR[31:2];
        fl0_d = ARLEN;
      end else begin
        fa1_d = ARADDR[31:2];
        fl1_d = ARLEN;
      end
      fq_n = fq_n + 2'd1;
    end
    fcnt_d = fq_n;
  end

  // Read-return stage: beat issued last cycle, data on MEM_RDATA now
  always_comb begin
    pv_d    = issue;
    pl_d    = issue && last_beat;
    po_d    = issue && oor;
    pe_data = po_q ? 32'd0 : MEM_RDATA;
    pe_resp = po_q ? 2'b11 : 2'b00;
    hd_data = pe_data;
    hd_resp = pe_resp;
    hd_last = pl_q;
    if (scnt_q != 2'd0) begin
      hd_data = sk0_data_q;
      hd_resp = sk0_resp_q;
      hd_last = sk0_last_q;
    end
  end

  assign RVALID = rvalid;
  assign RDATA  = rvalid ? hd_data : 32'd0;
  assign RRESP  = rvalid ? hd_resp : 2'b00;
  assign RLAST  = rvalid && hd_last;

  // Skid: park the returning beat unless it leaves on R this cycle
  always_comb begin
    sk_pop     = rpop && (scnt_q != 2'd0);
    cap        = pv_q && !(rpop && (scnt_q == 2'd0));
    sk0_data_d = sk0_data_q;
    sk0_resp_d = sk0_resp_q;
    sk0_last_d = sk0_last_q;
    sk1_data_d = sk1_data_q;
    sk1_resp_d = sk1_resp_q;
    sk1_last_d = sk1_last_q;
    sk_n       = scnt_q;
    if (sk_pop) begin
      sk0_data_d = sk1_data_q;
      sk0_resp_d = sk1_resp_q;
      sk0_last_d = sk1_last_q;
      sk_n       = sk_n - 2'd1;
    end
    if (cap) begin
      if (sk_n == 2'd0) begin
        sk0_data_d = pe_data;
        sk0_resp_d = pe_resp;
        sk0_last_d = pl_q;
      end else begin
        sk1_data_d = pe_data;
        sk1_resp_d = pe_resp;
        sk1_last_d = pl_q;
      end
      sk_n = sk_n + 2'd1;
    end
    scnt_d = sk_n;
  end

  // State registers; reset drops every queued and in-flight beat
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      fcnt_q     <= 2'd0;
      fa0_q      <= '0;
      fa1_q      <= '0;
      fl0_q      <= '0;
      fl1_q      <= '0;
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      pv_q       <= 1'b0;
      pl_q       <= 1'b0;
      po_q       <= 1'b0;
      scnt_q     <= 2'd0;
      sk0_data_q <= '0;
      sk1_data_q <= '0;
      sk0_resp_q <= '0;
      sk1_resp_q <= '0;
      sk0_last_q <= 1'b0;
      sk1_last_q <= 1'b0;
    end else begin
      fcnt_q     <= fcnt_d;
      fa0_q      <= fa0_d;
      fa1_q      <= fa1_d;
      fl0_q      <= fl0_d;
      fl1_q      <= fl1_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      pv_q       <= pv_d;
      pl_q       <= pl_d;
      po_q       <= po_d;
      scnt_q     <= scnt_d;
      sk0_data_q <= sk0_data_d;
      sk1_data_q <= sk1_data_d;
      sk0_resp_q <= sk0_resp_d;
      sk1_resp_q <= sk1_resp_d;
      sk0_last_q <= sk0_last_d;
      sk1_last_q <= sk1_last_d;
    end
  end

endmodule

// File: tb/tb_disp_vram_rdslave.sv
// tb_disp_vram_rdslave: directed + random bench for disp_vram_rdslave.
// Burst-level beat model, memory model and per-cycle R/MEM checker.
module tb_disp_vram_rdslave;

  localparam int AW = 16;
  localparam int MW = 16;

  logic          ACLK = 1'b0;
  logic          ARST = 1'b1;
  logic [31:0]   ARADDR = '0;
  logic [7:0]    ARLEN = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY = 1'b0;
  logic          MEM_EN;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_RDATA = '0;

  disp_vram_rdslave #(.MEM_AW(AW), .MEM_WORDS(MW)) dut (
    .ACLK(ACLK), .ARST(ARST),
    .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR),
    .MEM_RDATA(MEM_RDATA)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] ea_q[$];
  int          ar_cyc[$];
  int          lg_cyc[$];
  logic [31:0] lg_d[$];
  logic [1:0]  lg_r[$];
  logic        lg_l[$];

  int          vec = 0;
  int          miss = 0;
  int          cyc = 0;
  int          ahead = 0;
  logic [31:0] salt = '0;
  int          rr_mode = 0;
  logic        rr_lvl = 1'b0;
  logic [3:0]  pat = 4'b1001;
  int          pi = 0;
  logic        prev_stall = 1'b0;
  logic [34:0] prev_r = '0;
  logic [31:0] mw;
  beat_t       mb;

  function automatic logic [31:0] memval(logic [31:0] w);
    return w ^ salt;
  endfunction

  function automatic void chk(string nm, logic [63:0] a,
                              logic [63:0] e);
    vec++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, a, e, cyc);
    end
  endfunction

  function automatic void bad(string nm);
    vec++;
    miss++;
    $display("FAIL %s: got event want none (cycle %0d)", nm, cyc);
  endfunction

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(posedge ACLK)
    if (MEM_EN) MEM_RDATA <= memval(32'(MEM_ADDR));

  initial forever begin
    @(posedge ACLK);
    #1;
    if (rr_mode == 1) RREADY = 1'($urandom_range(0, 1));
    else if (rr_mode == 2) begin
      RREADY = pat[pi % 4];
      pi++;
    end else RREADY = rr_lvl;
  end

  initial forever begin
    @(negedge ACLK);
    if (ARST) begin
      chk("arready_in_reset", ARREADY, 0);
      exp_q.delete();
      ea_q.delete();
      ahead = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("r_hold", {RVALID, RLAST, RRESP, RDATA}, {1'b1, prev_r});
      if (ARVALID && ARREADY) begin
        ar_cyc.push_back(cyc);
        for (int k = 0; k <= int'(ARLEN); k++) begin
          mw = {2'b00, ARADDR[31:2]} + 32'(k);
          mb.l = (k == int'(ARLEN));
          if (mw >= 32'(MW)) begin
            mb.d = '0;
            mb.r = 2'b11;
          end else begin
            mb.d = memval(mw);
            mb.r = 2'b00;
            ea_q.push_back(mw);
          end
          exp_q.push_back(mb);
        end
      end
      if (MEM_EN) begin
        if (ea_q.size() == 0) bad("mem_en_unexpected");
        else chk("mem_addr", 32'(MEM_ADDR), ea_q.pop_front());
        ahead++;
      end
      if (RVALID && RREADY) begin
        lg_cyc.push_back(cyc);
        lg_d.push_back(RDATA);
        lg_r.push_back(RRESP);
        lg_l.push_back(RLAST);
        if (exp_q.size() == 0) bad("r_beat_unexpected");
        else begin
          mb = exp_q.pop_front();
          chk("r_beat", {RLAST, RRESP, RDATA}, {mb.l, mb.r, mb.d});
          if (mb.r == 2'b00) ahead--;
        end
      end
      if (MEM_EN) chk("mem_ahead_le2", ahead <= 2, 1);
      prev_stall = RVALID && !RREADY;
      prev_r = {RLAST, RRESP, RDATA};
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_ar(logic [31:0] a, logic [7:0] l);
    int n;
    bit done;
    n = 0;
    done = 0;
    ARADDR = a;
    ARLEN = l;
    ARVALID = 1'b1;
    while (!done) begin
      @(negedge ACLK);
      if (ARREADY) done = 1;
      else if (++n >= 300) begin
        bad("ar_timeout");
        done = 1;
      end
    end
    step();
    ARVALID = 1'b0;
  endtask

  task automatic wait_idle(int maxc);
    int n;
    n = 0;
    while (n < maxc) begin
      @(negedge ACLK);
      if (exp_q.size() == 0 && !RVALID && !MEM_EN) break;
      n++;
    end
    if (n >= maxc) bad("drain_timeout");
    step();
  endtask

  int b, a, nb;
  logic [31:0] ra;
  int kd;
  logic [7:0] rl;

  initial begin
    ARST = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_mem_en", MEM_EN, 0);
    chk("rst_mem_addr", MEM_ADDR, 0);
    step();
    ARST = 1'b0;
    @(negedge ACLK);
    chk("arready_after_rst", ARREADY, 1);
    rr_lvl = 1'b1;
    step();
    step();

    // single burst, latency and throughput
    b = lg_d.size();
    a = ar_cyc.size();
    send_ar(32'h20, 8'd7);
    wait_idle(100);
    nb = lg_d.size() - b;
    chk("t1_count", nb, 8);
    for (int i = 0; i < 8 && i < nb; i++) begin
      chk("t1_data", lg_d[b+i], 8 + i);
      chk("t1_resp", lg_r[b+i], 0);
      chk("t1_last", lg_l[b+i], i == 7);
      chk("t1_cycle", lg_cyc[b+i] - ar_cyc[a], 2 + i);
    end

    // back-to-back bursts, queue full blocking
    b = lg_d.size();
    a = ar_cyc.size();
    send_ar(32'h0, 8'd7);
    send_ar(32'h20, 8'd7);
    send_ar(32'h0, 8'd7);
    send_ar(32'h20, 8'd7);
    wait_idle(200);
    chk("t2_ar1", ar_cyc[a+1] - ar_cyc[a], 1);
    chk("t2_ar2", ar_cyc[a+2] - ar_cyc[a], 2);
    chk("t2_ar3_blocked", ar_cyc[a+3] - ar_cyc[a], 9);
    nb = lg_d.size() - b;
    chk("t2_count", nb, 32);
    for (int i = 0; i < 32 && i < nb; i++) begin
      chk("t2_data", lg_d[b+i], i % 16);
      chk("t2_last", lg_l[b+i], (i % 8) == 7);
      chk("t2_cycle", lg_cyc[b+i] - ar_cyc[a], 2 + i);
    end

    // backpressure pattern 1,0,0,1
    rr_mode = 2;
    step();
    b = lg_d.size();
    send_ar(32'h0, 8'd7);
    wait_idle(200);
    rr_mode = 0;
    nb = lg_d.size() - b;
    chk("t3_count", nb, 8);
    for (int i = 0; i < 8 && i < nb; i++) begin
      chk("t3_data", lg_d[b+i], i);
      chk("t3_last", lg_l[b+i], i == 7);
    end
    step();

    // burst crossing the populated range
    b = lg_d.size();
    send_ar(32'h38, 8'd3);
    wait_idle(100);
    nb = lg_d.size() - b;
    chk("t4_count", nb, 4);
    if (nb == 4) begin
      chk("t4_b0", {lg_l[b], lg_r[b], lg_d[b]}, {1'b0, 2'b00, 32'd14});
      chk("t4_b1", {lg_l[b+1], lg_r[b+1], lg_d[b+1]},
          {1'b0, 2'b00, 32'd15});
      chk("t4_b2", {lg_l[b+2], lg_r[b+2], lg_d[b+2]},
          {1'b0, 2'b11, 32'd0});
      chk("t4_b3", {lg_l[b+3], lg_r[b+3], lg_d[b+3]},
          {1'b1, 2'b11, 32'd0});
    end

    // reset in the middle of a burst
    b = lg_d.size();
    send_ar(32'h0, 8'd7);
    nb = 0;
    while (lg_d.size() - b < 3 && nb < 50) begin
      @(negedge ACLK);
      nb++;
    end
    if (nb >= 50) bad("t5_beats_timeout");
    step();
    ARST = 1'b1;
    @(negedge ACLK);
    chk("t5_arready_rst", ARREADY, 0);
    step();
    ARST = 1'b0;
    @(negedge ACLK);
    chk("t5_rvalid", RVALID, 0);
    chk("t5_rlast", RLAST, 0);
    chk("t5_rdata", RDATA, 0);
    chk("t5_mem_en", MEM_EN, 0);
    chk("t5_arready", ARREADY, 1);
    step();
    b = lg_d.size();
    a = ar_cyc.size();
    send_ar(32'h0, 8'd7);
    wait_idle(100);
    nb = lg_d.size() - b;
    chk("t5_count", nb, 8);
    for (int i = 0; i < 8 && i < nb; i++) begin
      chk("t5_data", lg_d[b+i], i);
      chk("t5_last", lg_l[b+i], i == 7);
      chk("t5_cycle", lg_cyc[b+i] - ar_cyc[a], 2 + i);
    end

    // single-beat bursts back to back
    b = lg_d.size();
    a = ar_cyc.size();
    for (int i = 1; i <= 4; i++) send_ar(32'(i * 4), 8'd0);
    wait_idle(100);
    nb = lg_d.size() - b;
    chk("t6_count", nb, 4);
    for (int i = 0; i < 4 && i < nb; i++) begin
      chk("t6_data", lg_d[b+i], i + 1);
      chk("t6_last", lg_l[b+i], 1);
      chk("t6_ar_cycle", ar_cyc[a+i] - ar_cyc[a], i);
      chk("t6_cycle", lg_cyc[b+i] - ar_cyc[a], 2 + i);
    end

    // random traffic against the beat model
    salt = $urandom;
    rr_mode = 1;
    for (int n = 0; n < 150; n++) begin
      kd = $urandom_range(0, 9);
      if (kd < 7)
        ra = 32'($urandom_range(0, 20) * 4 + $urandom_range(0, 3));
      else if (kd < 9) ra = $urandom;
      else ra = 32'h30;
      if ($urandom_range(0, 3) == 0) rl = 8'($urandom_range(0, 20));
      else rl = 8'd7;
      send_ar(ra, rl);
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle(4000);
    rr_mode = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
